// File: rtl/time_counter_24h.sv
// rtl/time_counter_24h.sv - 24 h packed-BCD time-of-day counter with prescaler and set mode
// Advances HH:MM:SS once per TICK_DIV clocks; set mode steps hours/minutes independently.
module time_counter_24h #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        set_mode,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        clr_sec,
  output logic [19:0] time_out,
  output logic        sec_tick,
  output logic        day_wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    hour_q, hour_d;
  logic [6:0]    min_q, min_d;
  logic [6:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          tick;
  logic          time_ok;
  logic          update;

  // BCD 00..59 increment with wrap
  function automatic logic [6:0] inc_60(input logic [6:0] v);
    if (v == 7'h59)
      return 7'h00;
    else if (v[3:0] == 4'd9)
      return {v[6:4] + 3'd1, 4'd0};
    else
      return {v[6:4], v[3:0] + 4'd1};
  endfunction

  // BCD 00..23 increment with wrap
  function automatic logic [5:0] inc_24(input logic [5:0] v);
    if (v == 6'h23)
      return 6'h00;
    else if (v[3:0] == 4'd9)
      return {v[5:4] + 2'd1, 4'd0};
    else
      return {v[5:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;

    tick    = run_en && !set_mode && (presc_q == PRESC_MAX);
    time_ok = (sec_q[3:0] <= 4'd9) && (sec_q[6:4] <= 3'd5) &&
              (min_q[3:0] <= 4'd9) && (min_q[6:4] <= 3'd5) &&
              (hour_q[3:0] <= 4'd9) && (hour_q[5:4] <= 2'd2) &&
              !((hour_q[5:4] == 2'd2) && (hour_q[3:0] > 4'd3));
    update  = clr_sec || tick || (set_mode && (inc_hour || inc_min));

    if (clr_sec || set_mode)
      presc_d = '0;
    else if (run_en)
      presc_d = tick ? '0 : presc_q + 1'b1;

    // clr_sec wins over a coincident tick: no increment, no pulse
    if (clr_sec) begin
      sec_d = 7'h00;
    end else if (tick) begin
      sec_tick_d = 1'b1;
      sec_d      = inc_60(sec_q);
      if (sec_q == 7'h59) begin
        min_d = inc_60(min_q);
        if (min_q == 7'h59) begin
          hour_d     = inc_24(hour_q);
          day_wrap_d = (hour_q == 6'h23);
        end
      end
    end

    if (set_mode) begin
      if (inc_min)
        min_d = inc_60(min_q);
      if (inc_hour)
        hour_d = inc_24(hour_q);
    end

    if (update && !time_ok) begin
      hour_d     = 6'h00;
      min_d      = 7'h00;
      sec_d      = 7'h00;
      day_wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      hour_q     <= 6'h00;
      min_q      <= 7'h00;
      sec_q      <= 7'h00;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign time_out = {hour_q, min_q, sec_q};
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule
